// File: rtl/pps_loop_ctrl_pkg.sv
// Shared types and constants for the PPS-disciplined VCXO loop controller.
// The default widths match the 4 MHz VCXO with a 10-bit residue counter.
package pps_loop_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAcquire,
    StTrack,
    StLocked,
    StHoldover
  } state_e;

  localparam int unsigned PwmWDefault       = 10;
  localparam int unsigned PwmMid            = 1 << (PwmWDefault - 1);
  localparam int unsigned NominalResDefault = 256;

  function automatic int unsigned abs_err(input int err);
    return (err < 0) ? unsigned'(-err) : unsigned'(err);
  endfunction

endpackage

// File: rtl/pps_loop_ctrl_if.sv
// Bundle between the loop controller, the residue counter, the PWM generator and the panel.
// The master side is the controller; the slave side is everything around it.
interface pps_loop_ctrl_if #(
  parameter int unsigned CntW = 10,
  parameter int unsigned PwmW = 10
);
  logic            pps;
  logic            btn_n;
  logic [CntW-1:0] residue;
  logic            cnt_clr;
  logic [PwmW-1:0] pwm_set;
  logic            pwm_load;
  logic            st_low;
  logic            st_ok;
  logic            st_high;
  logic            locked;
  logic            holdover;
  logic            pps_toggle;

  modport master (
    input  pps, btn_n, residue,
    output cnt_clr, pwm_set, pwm_load, st_low, st_ok, st_high, locked, holdover, pps_toggle
  );

  modport slave (
    output pps, btn_n, residue,
    input  cnt_clr, pwm_set, pwm_load, st_low, st_ok, st_high, locked, holdover, pps_toggle
  );
endinterface

// File: rtl/pps_loop_ctrl_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge detector.
// level and rise are aligned: rise is high in the first cycle that level is high.
module pps_loop_ctrl_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign level = sync_q[2];
  assign rise  = rise_q;

endmodule

// File: rtl/pps_loop_ctrl.sv
// Supervised PPS discipline loop: clears the residue counter on each qualified PPS edge,
// steps the PWM setpoint adaptively and runs acquire/track/lock/holdover sequencing.
module pps_loop_ctrl
  import pps_loop_ctrl_pkg::*;
#(
  parameter int unsigned CntW       = 10,
  parameter int unsigned PwmW       = 10,
  parameter int unsigned NominalRes = NominalResDefault,
  parameter int unsigned Tol        = 8,
  parameter int unsigned AcqThr     = 64,
  parameter int unsigned MaxStep    = 16,
  parameter int unsigned LockN      = 4,
  parameter int unsigned TmoCyc     = 5000000,
  parameter int unsigned TmoW       = 23
) (
  input logic            clk,
  input logic            rst_n,
  pps_loop_ctrl_if.master bus
);

  localparam int unsigned LockW = $clog2(LockN + 1);
  localparam int PwmMax = (1 << PwmW) - 1;
  localparam logic [PwmW-1:0] PwmRst = PwmW'(1) << (PwmW - 1);

  logic pps_rise, btn_level, btn_rise, unused_pps_level;

  pps_loop_ctrl_sync_edge u_pps_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.pps),
    .level    (unused_pps_level),
    .rise     (pps_rise)
  );

  // Button is synchronized inverted so "pressed" is the rising level.
  pps_loop_ctrl_sync_edge u_btn_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (~bus.btn_n),
    .level    (btn_level),
    .rise     (btn_rise)
  );

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [LockW-1:0]  lock_q, lock_d;
  logic [PwmW-1:0]   pwm_q, pwm_d;
  logic              load_q, load_d;
  logic [2:0]        st_q, st_d;  // {low, ok, high}
  logic              locked_q, locked_d;
  logic              hold_q, hold_d;
  logic              toggle_q;

  logic signed [CntW-1:0] err_s;
  int                     err_i;
  int unsigned            abs_e, acq_step;
  logic                   in_win, active;
  int                     step, pwm_calc;

  assign err_s  = $signed(bus.residue - CntW'(NominalRes));
  assign err_i  = int'(err_s);
  assign abs_e  = abs_err(err_i);
  assign in_win = (abs_e <= Tol);
  assign active = state_q inside {StAcquire, StTrack, StLocked};

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    lock_d   = lock_q;
    pwm_d    = pwm_q;
    load_d   = 1'b0;
    st_d     = st_q;
    locked_d = locked_q;
    hold_d   = hold_q;
    acq_step = abs_e >> 2;
    step     = 0;
    pwm_calc = int'(pwm_q);

    if (acq_step < 1) acq_step = 1;
    if (acq_step > MaxStep) acq_step = MaxStep;

    if (!active || pps_rise) begin
      tmo_d = '0;
    end else if (tmo_q < TmoW'(TmoCyc)) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (btn_level) begin
      state_d  = StIdle;
      tmo_d    = '0;
      lock_d   = '0;
      pwm_d    = PwmRst;
      load_d   = btn_rise;
      st_d     = 3'b111;
      locked_d = 1'b0;
      hold_d   = 1'b0;
    end else if (pps_rise) begin
      if (!active) begin
        // First edge after idle or holdover only re-references the counter.
        state_d = StAcquire;
        hold_d  = 1'b0;
      end else begin
        step = (state_q == StAcquire) ? int'(acq_step) : (in_win ? 0 : 1);
        if (err_i < 0) pwm_calc = pwm_calc + step;
        else if (err_i > 0) pwm_calc = pwm_calc - step;
        if (pwm_calc < 0) pwm_calc = 0;
        if (pwm_calc > PwmMax) pwm_calc = PwmMax;
        pwm_d  = pwm_calc[PwmW-1:0];
        load_d = (pwm_d != pwm_q);
        st_d   = in_win ? 3'b010 : ((err_i < 0) ? 3'b100 : 3'b001);

        case (state_q)
          StAcquire: begin
            if (in_win) begin
              state_d = StTrack;
              lock_d  = LockW'(1);
            end
          end
          StTrack: begin
            if (in_win) begin
              lock_d = lock_q + 1'b1;
              if (int'(lock_q) + 1 >= int'(LockN)) begin
                state_d  = StLocked;
                locked_d = 1'b1;
              end
            end else begin
              lock_d = '0;
              if (abs_e > AcqThr) state_d = StAcquire;
            end
          end
          default: begin
            if (!in_win) begin
              state_d  = StTrack;
              lock_d   = '0;
              locked_d = 1'b0;
            end
          end
        endcase
      end
    end else if (active && tmo_d == TmoW'(TmoCyc)) begin
      state_d  = StHoldover;
      tmo_d    = '0;
      lock_d   = '0;
      st_d     = 3'b101;
      locked_d = 1'b0;
      hold_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      lock_q   <= '0;
      pwm_q    <= PwmRst;
      load_q   <= 1'b0;
      st_q     <= 3'b101;
      locked_q <= 1'b0;
      hold_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      lock_q   <= lock_d;
      pwm_q    <= pwm_d;
      load_q   <= load_d;
      st_q     <= st_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
      toggle_q <= toggle_q ^ pps_rise;
    end
  end

  assign bus.cnt_clr    = pps_rise;
  assign bus.pwm_set    = pwm_q;
  assign bus.pwm_load   = load_q;
  assign bus.st_low     = st_q[2];
  assign bus.st_ok      = st_q[1];
  assign bus.st_high    = st_q[0];
  assign bus.locked     = locked_q;
  assign bus.holdover   = hold_q;
  assign bus.pps_toggle = toggle_q ^ pps_rise;

endmodule

// File: tb/tb_pps_loop_ctrl.sv
// Randomized bench for pps_loop_ctrl against a rule-level loop model.
// The timeout is shortened so holdover is reachable in a short run.
module tb_pps_loop_ctrl;
  import pps_loop_ctrl_pkg::*;

  localparam int TmoCycTb = 300;
  localparam int Nom = 256, TolM = 8, ThrM = 64, MaxM = 16, LockM = 4, PMax = 1023;
  localparam int MIdle = 0, MAcq = 1, MTrk = 2, MLck = 3, MHold = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pps_loop_ctrl_if #(.CntW(10), .PwmW(10)) bus ();

  pps_loop_ctrl #(
    .CntW(10), .PwmW(10), .NominalRes(256), .Tol(8), .AcqThr(64), .MaxStep(16), .LockN(4),
    .TmoCyc(TmoCycTb), .TmoW(23)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int       m_mode, m_lc, m_pwm;
  logic [2:0] m_st;
  logic     m_locked, m_hold, m_toggle, m_load;

  function automatic logic [17:0] obs_vec();
    return {bus.cnt_clr, bus.pps_toggle, bus.pwm_set, bus.pwm_load,
            bus.st_low, bus.st_ok, bus.st_high, bus.locked, bus.holdover};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {1'b0, m_toggle, 10'(m_pwm), m_load, m_st, m_locked, m_hold};
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_lc = 0; m_pwm = PwmMid; m_st = 3'b101;
    m_locked = 1'b0; m_hold = 1'b0; m_toggle = 1'b0; m_load = 1'b0;
  endtask

  task automatic model_edge(input int res);
    int e, a, st, np;
    e = res - Nom;
    if (e > 511) e -= 1024;
    if (e < -512) e += 1024;
    a = (e < 0) ? -e : e;
    m_load = 1'b0;
    if (m_mode == MIdle || m_mode == MHold) begin
      m_mode = MAcq;
      m_hold = 1'b0;
      return;
    end
    if (m_mode == MAcq) st = (a / 4 < 1) ? 1 : ((a / 4 > MaxM) ? MaxM : a / 4);
    else st = (a > TolM) ? 1 : 0;
    np = m_pwm + ((e < 0) ? st : ((e > 0) ? -st : 0));
    if (np < 0) np = 0;
    if (np > PMax) np = PMax;
    m_load = (np != m_pwm);
    m_pwm = np;
    m_st = (a <= TolM) ? 3'b010 : ((e < 0) ? 3'b100 : 3'b001);
    if (m_mode == MAcq) begin
      if (a <= TolM) begin m_mode = MTrk; m_lc = 1; end
    end else if (m_mode == MTrk) begin
      if (a <= TolM) begin
        m_lc++;
        if (m_lc >= LockM) begin m_mode = MLck; m_locked = 1'b1; end
      end else begin
        m_lc = 0;
        if (a > ThrM) m_mode = MAcq;
      end
    end else if (a > TolM) begin
      m_mode = MTrk; m_lc = 0; m_locked = 1'b0;
    end
  endtask

  // One PPS pulse: checks clear latency/toggle in cycle E, then the registered outputs.
  task automatic pps_edge(input int res, input string tag);
    int n;
    @(negedge clk);
    bus.residue = 10'(res);
    bus.pps = 1'b1;
    n = 0;
    while (bus.cnt_clr !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    m_toggle = ~m_toggle;
    n_checks++;
    if (n != 3 || bus.pps_toggle !== m_toggle) begin
      n_fail++;
      $display("FAIL %s clr_edge: got %0d edges toggle=%b, want 3 edges toggle=%b",
               tag, n, bus.pps_toggle, m_toggle);
    end
    model_edge(res);
    @(posedge clk); #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL %s outputs res=%0d: got %h want %h", tag, res, obs_vec(), exp_vec());
    end
    @(negedge clk);
    bus.pps = 1'b0;
    m_load = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.pps = 1'b0; bus.btn_n = 1'b1; bus.residue = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_first_edge();
    pps_edge(300, "first_edge");
  endtask

  task automatic test_acquire();
    pps_edge(200, "acq_step14");
    pps_edge(900, "acq_clamp16");
    n_checks++;
    if (bus.pwm_set !== 10'd542) begin
      n_fail++; $display("FAIL acq_value: got %0d want 542", bus.pwm_set);
    end
  endtask

  task automatic test_lock();
    repeat (4) pps_edge(254, "lock_seq");
    n_checks++;
    if (bus.locked !== 1'b1 || bus.st_ok !== 1'b1) begin
      n_fail++; $display("FAIL lock_reached: got locked=%b ok=%b want 1 1", bus.locked, bus.st_ok);
    end
    pps_edge(270, "lock_loss");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9, 0) < 7) r = int'($urandom_range(272, 240));
      else r = int'($urandom_range(1023, 0));
      pps_edge(r, "random");
    end
  endtask

  task automatic test_saturation();
    int k;
    k = 0;
    while (!(m_mode == MAcq && m_pwm == PMax) && k < 80) begin
      pps_edge(900, "drive_high");
      k++;
    end
    n_checks++;
    if (k >= 80) begin
      n_fail++; $display("FAIL sat_reach: got pwm=%0d want %0d", bus.pwm_set, PMax);
    end
    pps_edge(216, "sat_high");
  endtask

  task automatic test_holdover();
    int n;
    repeat (4) pps_edge(256, "relock");
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL relock: got locked=%b want 1", bus.locked);
    end
    n = 0;
    while (bus.holdover !== 1'b1 && n < TmoCycTb + 100) begin @(posedge clk); #1; n++; end
    m_mode = MHold; m_hold = 1'b1; m_locked = 1'b0; m_st = 3'b101; m_lc = 0;
    n_checks++;
    if (n < TmoCycTb - 20 || n > TmoCycTb + 20) begin
      n_fail++; $display("FAIL holdover_time: got %0d cycles want about %0d", n, TmoCycTb);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL holdover_outputs: got %h want %h", obs_vec(), exp_vec());
    end
    pps_edge(400, "hold_exit");
    pps_edge(300, "reacquire");
  endtask

  task automatic test_recenter();
    int n;
    @(negedge clk);
    bus.residue = 10'd300; bus.btn_n = 1'b0; bus.pps = 1'b1;
    n = 0;
    while (bus.cnt_clr !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    m_toggle = ~m_toggle;
    n_checks++;
    if (n != 3 || bus.pps_toggle !== m_toggle) begin
      n_fail++; $display("FAIL btn_clr: got %0d edges toggle=%b want 3 %b", n, bus.pps_toggle, m_toggle);
    end
    m_mode = MIdle; m_pwm = PwmMid; m_load = 1'b1; m_st = 3'b111; m_locked = 1'b0; m_lc = 0;
    @(posedge clk); #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL recenter: got %h want %h", obs_vec(), exp_vec());
    end
    m_load = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL recenter_one_load: got %h want %h", obs_vec(), exp_vec());
    end
    @(negedge clk); bus.pps = 1'b0;
    repeat (5) @(negedge clk);
    bus.btn_n = 1'b1;
    repeat (TmoCycTb + 50) @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL idle_no_timeout: got %h want %h", obs_vec(), exp_vec());
    end
    pps_edge(300, "post_recenter_first");
    pps_edge(200, "post_recenter_acq");
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus.residue = 10'd300; bus.pps = 1'b1;
    n = 0;
    while (bus.cnt_clr !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
    end
    repeat (3) @(negedge clk);
    bus.pps = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_no_pulse: got %h want %h", obs_vec(), exp_vec());
    end
    pps_edge(200, "after_reset_first");
    pps_edge(200, "after_reset_acq");
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_acquire();
    test_lock();
    test_random();
    test_saturation();
    test_holdover();
    test_recenter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
